dino_game_core: RTL
===================

# dino_game_core

Frame-rate game-state engine for the dino runner: owns the run/over state machine, scrolls `N_OBS` obstacles, keeps a BCD current score and high score, and optionally ramps scroll speed. It sits between the VGA timing generator and the pixel compositor. It consumes the per-frame pulse and the compositor's per-pixel collision flag. It drives obstacle positions and score digits back to the compositor's sprite and digit ROM addressing.

## Interface
Parameters:
- `N_OBS`, 2: number of obstacles (1..4).
- `X_W`, 10: obstacle x-coordinate width.
- `SPAWN_X`, 550: x of obstacle 0 at game start.
- `OBS_GAP`, 200: initial spacing between consecutive obstacles.
- `MIN_X`, 10: left wrap threshold.
- `NUM_DIGITS`, 5: BCD score digits.
- `SCORE_DIV`, 32: frames per score point.
- `SPEED_INIT`, 1: pixels moved per frame at start.
- `SPEED_MAX`, 4: speed ceiling.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low; clears everything including high score.
- `frame_tick` in 1: single-cycle pulse per frame, already synchronous to `clk`.
- `start` in 1: level from jump button.
- `hit` in 1: dino-opaque AND obstacle-opaque for the current pixel.
- `state` out 2: IDLE=0, RUN=1, OVER=2.
- `game_on` out 1: state==RUN.
- `game_over` out 1: state==OVER.
- `obs_x` out N_OBS*X_W: packed x positions, obstacle i at [i*X_W +: X_W].
- `score_bcd` out 4*NUM_DIGITS: current score, digit 0 at LSBs.
- `high_bcd` out 4*NUM_DIGITS: high score.
- `new_high` out 1: last finished run set a new high score.
- `speed` out 3: current pixels per frame.

## Operation
- `start_edge` = `start` AND NOT registered `start`. Registered `start` resets to 1, so a button held through reset does not start the game.
- FSM:
  - IDLE -> RUN on `start_edge`.
  - RUN -> OVER on `hit`.
  - OVER -> RUN on `start_edge`.
  - No other transitions.
- Entry to RUN, from either IDLE or OVER:
  - `obs_x[i]` = SPAWN_X + i*OBS_GAP.
  - Score = 0, frame divider = 0, `speed` = SPEED_INIT.
  - `new_high` = 0.
- Scrolling, on `frame_tick` while in RUN with no `hit` that cycle, each obstacle independently:
  - if `obs_x[i]` < MIN_X + speed: `obs_x[i]` = `obs_x[i]` + N_OBS*OBS_GAP − speed. This preserves spacing exactly.
  - else: `obs_x[i]` = `obs_x[i]` − speed.
- Score:
  - A frame divider counts `frame_tick` in RUN, 0..SCORE_DIV−1.
  - On wrap, the BCD score increments with ripple carry.
  - At all-9s the score saturates; no wrap.
- High score, on the RUN->OVER cycle:
  - If `score_bcd` > `high_bcd` (unsigned compare of packed BCD), copy the score to `high_bcd` and set `new_high`=1.
  - `new_high` holds until the next RUN entry.
- In IDLE and OVER, obstacles, score and speed are frozen.

## Timing
- Reset values: state=IDLE, game_on=0, game_over=0, obs_x[i]=SPAWN_X+i*OBS_GAP, score_bcd=0, high_bcd=0, new_high=0, speed=SPEED_INIT.
- All outputs are registered. A `hit` at edge k gives game_over=1 after edge k+1.
- `obs_x` updates one cycle after `frame_tick`.
- `hit` and `frame_tick` in the same cycle: OVER wins, and neither movement nor score update occurs.
- `start_edge` and `frame_tick` in the same cycle in IDLE/OVER: enter RUN, no movement that frame.
- The score increment and the high-score compare never coincide, because the increment is suppressed on the hit cycle.
- `reset` asserted mid-run returns all outputs to their reset values immediately (asynchronous). Deassertion is synchronised externally.

## Configuration
- `DINO_SPEEDUP_EN` defined:
  - Each time the score's tens and units digits roll to 00 (every 100 points), `speed` increments by 1, saturating at SPEED_MAX.
  - The new speed applies from the next `frame_tick`.
- Not defined: `speed` is constant SPEED_INIT, and the speed-update logic is absent.

## Structure
- Package `dino_pkg` holds:
  - the `game_state_t` enum (IDLE/RUN/OVER);
  - the `bcd_digit_t` 4-bit type;
  - the default localparams for SPAWN_X, MIN_X and the ground height.
- Sub-module `bcd_counter`, parameterised on NUM_DIGITS:
  - synchronous clear, increment, saturate;
  - outputs a `roll100` pulse used by the speedup logic.

## Test plan
- Reset, then `start` held high through release -> state stays IDLE. A fresh 0->1 on `start` -> state=RUN on the following cycle.
- N_OBS=2, RUN, 5 `frame_tick`s, speed 1 -> obs_x = {745, 545}. Obstacle at x=10 with speed 1 -> next x = 10+400−1 = 409.
- SCORE_DIV=32, 96 frames in RUN -> score_bcd=0x00003. Score preset to 0x00099 plus one divider wrap -> 0x00100. Score 0x99999 stays 0x99999.
- `hit` coincident with `frame_tick` at score 0x00042, high score 0x00017 -> obs_x unchanged, game_over=1, high_bcd=0x00042, new_high=1. Next `start_edge` -> score 0, new_high=0, high_bcd kept.
- With `DINO_SPEEDUP_EN` and SPEED_MAX=4: score crossing 100, 200, 300, 400 -> speed 2, 3, 4, 4. Without the macro -> speed stays 1.
- `reset` low mid-RUN -> all outputs at reset values in the same cycle, including high_bcd=0.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared types and default geometry for the dino runner game core.
package dino_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StOver = 2'd2
  } game_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned SpawnXDefault = 550;
  localparam int unsigned MinXDefault   = 10;
  localparam int unsigned GroundY       = 400;

endpackage

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD counter with synchronous clear and a pulse on every x00 rollover.
module bcd_counter
  import dino_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    inc,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    roll100
);

  bcd_digit_t [NUM_DIGITS-1:0] count_q, count_d;
  logic all_nines;
  logic carry;

  always_comb begin
    all_nines = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (count_q[i] != 4'd9) all_nines = 1'b0;
    end
    count_d = count_q;
    carry   = inc & ~all_nines;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count_q[i] == 4'd9) begin
          count_d[i] = 4'd0;
        end else begin
          count_d[i] = count_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
    if (clear) count_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

  if (NUM_DIGITS >= 2) begin : g_roll
    assign roll100 = inc & ~clear & ~all_nines & (count_q[0] == 4'd9) & (count_q[1] == 4'd9);
  end else begin : g_no_roll
    assign roll100 = 1'b0;
  end

endmodule

// File: rtl/dino_game_core.sv
// Frame-rate game-state engine: run/over FSM, obstacle scrolling, BCD score and high score.
// Define DINO_SPEEDUP_EN to ramp scroll speed by one every 100 points up to SPEED_MAX.
module dino_game_core
  import dino_pkg::*;
#(
  parameter int unsigned N_OBS      = 2,
  parameter int unsigned X_W        = 10,
  parameter int unsigned SPAWN_X    = SpawnXDefault,
  parameter int unsigned OBS_GAP    = 200,
  parameter int unsigned MIN_X      = MinXDefault,
  parameter int unsigned NUM_DIGITS = 5,
  parameter int unsigned SCORE_DIV  = 32,
  parameter int unsigned SPEED_INIT = 1,
  parameter int unsigned SPEED_MAX  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    start,
  input  logic                    hit,
  output logic [1:0]              state,
  output logic                    game_on,
  output logic                    game_over,
  output logic [N_OBS*X_W-1:0]    obs_x,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] high_bcd,
  output logic                    new_high,
  output logic [2:0]              speed
);

  localparam int unsigned DivW    = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int unsigned WrapAdd = N_OBS * OBS_GAP;

  game_state_t                 state_q;
  logic                        start_q, game_on_q, game_over_q, new_high_q;
  logic [N_OBS-1:0][X_W-1:0]   obs_q;
  logic [DivW-1:0]             div_q;
  logic [4*NUM_DIGITS-1:0]     high_q;
  logic [4*NUM_DIGITS-1:0]     score;
  logic [2:0]                  speed_q;
  logic                        start_edge, run_enter, step, score_inc, roll100;

  function automatic logic [X_W-1:0] spawn_pos(input int unsigned idx);
    return X_W'(SPAWN_X + idx * OBS_GAP);
  endfunction

  assign start_edge = start & ~start_q;
  assign run_enter  = start_edge && (state_q != StRun);
  assign step       = (state_q == StRun) && frame_tick && !hit;
  assign score_inc  = step && (div_q == DivW'(SCORE_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      start_q     <= 1'b1;  // a button held through reset must not start a game
      game_on_q   <= 1'b0;
      game_over_q <= 1'b0;
      new_high_q  <= 1'b0;
      high_q      <= '0;
      div_q       <= '0;
      for (int unsigned i = 0; i < N_OBS; i++) obs_q[i] <= spawn_pos(i);
    end else begin
      start_q <= start;
      case (state_q)
        StIdle, StOver: begin
          if (start_edge) begin
            state_q     <= StRun;
            game_on_q   <= 1'b1;
            game_over_q <= 1'b0;
            new_high_q  <= 1'b0;
            div_q       <= '0;
            for (int unsigned i = 0; i < N_OBS; i++) obs_q[i] <= spawn_pos(i);
          end
        end
        StRun: begin
          if (hit) begin
            state_q     <= StOver;
            game_on_q   <= 1'b0;
            game_over_q <= 1'b1;
            if (score > high_q) begin
              high_q     <= score;
              new_high_q <= 1'b1;
            end
          end else if (frame_tick) begin
            div_q <= (div_q == DivW'(SCORE_DIV - 1)) ? '0 : div_q + DivW'(1);
            // Wrapping by the full ring length keeps the inter-obstacle spacing exact.
            for (int unsigned i = 0; i < N_OBS; i++) begin
              if (32'(obs_q[i]) < MIN_X + 32'(speed_q)) begin
                obs_q[i] <= X_W'(32'(obs_q[i]) + WrapAdd - 32'(speed_q));
              end else begin
                obs_q[i] <= obs_q[i] - X_W'(speed_q);
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DINO_SPEEDUP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      speed_q <= 3'(SPEED_INIT);
    end else if (run_enter) begin
      speed_q <= 3'(SPEED_INIT);
    end else if (roll100 && (speed_q < 3'(SPEED_MAX))) begin
      speed_q <= speed_q + 3'd1;
    end
  end
`else
  logic unused_roll100;
  assign unused_roll100 = roll100;
  assign speed_q        = 3'(SPEED_INIT);
`endif

  bcd_counter #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_score (
    .clk     (clk),
    .reset   (reset),
    .clear   (run_enter),
    .inc     (score_inc),
    .count   (score),
    .roll100 (roll100)
  );

  assign state     = state_q;
  assign game_on   = game_on_q;
  assign game_over = game_over_q;
  assign obs_x     = obs_q;
  assign score_bcd = score;
  assign high_bcd  = high_q;
  assign new_high  = new_high_q;
  assign speed     = speed_q;

endmodule
